// File: rtl/fft_stage_scheduler_if.sv
// ---------------------------------------------------------------------------
// fft_stage_scheduler_if
// Bundle of the handshake / address signals between the FFT stage scheduler
// and the surrounding datapath (sample RAM, twiddle ROM, butterfly).
//
// Signals (direction as seen from the scheduler, i.e. the master modport):
//   i_start           in   start one FFT cycle (only honoured in IDLE)
//   i_sample_valid    in   input sample present on the datapath
//   o_ld_ready        out  scheduler is loading samples
//   o_ld_en           out  RAM load write enable (accepted sample)
//   o_ld_addr         out  bit-reversed load address
//   o_rd_en           out  butterfly operand read enable
//   o_rd_addr_a/b     out  upper / lower operand addresses
//   o_tw_addr         out  twiddle ROM index k of W_N^k
//   o_wr_en           out  butterfly result write enable
//   o_wr_addr_a/b     out  result A / B addresses
//   o_stage           out  current stage index
//   o_busy            out  high whenever not IDLE
//   o_FFT_cycle_done  out  one-cycle completion pulse
//   o_wr_scale        out  only with FFT_SCALE_EN: scale-by-1/2 request
//
// Build macro: FFT_SCALE_EN adds o_wr_scale.
// STAGES must be at least 2 (the twiddle index is STAGES-1 bits wide).
// ---------------------------------------------------------------------------
interface fft_stage_scheduler_if #(
    parameter int STAGES = 4
);
    localparam int STAGE_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic                 i_start;
    logic                 i_sample_valid;
    logic                 o_ld_ready;
    logic                 o_ld_en;
    logic [STAGES-1:0]    o_ld_addr;
    logic                 o_rd_en;
    logic [STAGES-1:0]    o_rd_addr_a;
    logic [STAGES-1:0]    o_rd_addr_b;
    logic [STAGES-2:0]    o_tw_addr;
    logic                 o_wr_en;
    logic [STAGES-1:0]    o_wr_addr_a;
    logic [STAGES-1:0]    o_wr_addr_b;
    logic [STAGE_W-1:0]   o_stage;
    logic                 o_busy;
    logic                 o_FFT_cycle_done;
`ifdef FFT_SCALE_EN
    logic                 o_wr_scale;
`endif

    // Scheduler side
    modport master (
        input  i_start, i_sample_valid,
        output o_ld_ready, o_ld_en, o_ld_addr,
               o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
               o_wr_en, o_wr_addr_a, o_wr_addr_b,
               o_stage, o_busy, o_FFT_cycle_done
`ifdef FFT_SCALE_EN
        , output o_wr_scale
`endif
    );

    // Datapath side
    modport slave (
        output i_start, i_sample_valid,
        input  o_ld_ready, o_ld_en, o_ld_addr,
               o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
               o_wr_en, o_wr_addr_a, o_wr_addr_b,
               o_stage, o_busy, o_FFT_cycle_done
`ifdef FFT_SCALE_EN
        , input o_wr_scale
`endif
    );
endinterface

// File: rtl/fft_stage_scheduler.sv
// ---------------------------------------------------------------------------
// fft_stage_scheduler
// Control FSM and address generator for an in-place iterative radix-2 DIT
// FFT of N = 2**STAGES points on one shared butterfly and a dual-port RAM.
//   LOAD  : N samples written to RAM at bit-reversed addresses.
//   CALC  : one butterfly read per cycle (N/2 per stage) with twiddle index.
//   DRAIN : BFLY_LATENCY cycles so the stage's last write lands before the
//           next stage's first read (no read-after-write overlap).
//   DONE  : one-cycle o_FFT_cycle_done pulse; result is in natural order.
//
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    fft_stage_scheduler_if.master (see interface file for signals)
//
// Parameters:
//   STAGES        number of radix-2 stages (>= 2)
//   BFLY_LATENCY  read-issue to write-back latency, 1..8
//
// Build macro: FFT_SCALE_EN adds o_wr_scale (asserted with o_wr_en).
// ---------------------------------------------------------------------------
module fft_stage_scheduler #(
    parameter int STAGES       = 4,
    parameter int BFLY_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fft_stage_scheduler_if.master bus
);
    localparam int STAGE_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int TW_W    = STAGES - 1;
    localparam int LAT_W   = $clog2(BFLY_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [STAGES-1:0]    r_n;
    logic [TW_W-1:0]      r_k;
    logic [STAGE_W-1:0]   r_s;
    logic [LAT_W-1:0]     r_dcnt;
    logic                 r_rd_en;
    logic [STAGES-1:0]    r_rd_a;
    logic [STAGES-1:0]    r_rd_b;
    logic [TW_W-1:0]      r_tw;
    logic                 r_busy;
    logic                 r_done;

    logic [BFLY_LATENCY-1:0] r_wv_p;
    logic [STAGES-1:0]       r_wa_p [BFLY_LATENCY];
    logic [STAGES-1:0]       r_wb_p [BFLY_LATENCY];

    logic                 w_ld_en;

    function automatic logic [STAGES-1:0] f_bitrev(input logic [STAGES-1:0] v);
        logic [STAGES-1:0] r;
        for (int i = 0; i < STAGES; i++) begin
            r[i] = v[STAGES-1-i];
        end
        return r;
    endfunction

    // Upper operand: group*2*half + pos. With half = 2**s this is k with a
    // zero inserted at bit position s.
    function automatic logic [STAGES-1:0] f_addr_a(input logic [STAGE_W-1:0] s,
                                                   input logic [TW_W-1:0]    k);
        logic [STAGES-1:0] kx;
        logic [STAGES-1:0] mask;
        kx   = {1'b0, k};
        mask = (STAGES'(1) << s) - STAGES'(1);
        return ((kx & ~mask) << 1) | (kx & mask);
    endfunction

    // Lower operand sits exactly half above the upper one (bit s is clear in a).
    function automatic logic [STAGES-1:0] f_addr_b(input logic [STAGE_W-1:0] s,
                                                   input logic [TW_W-1:0]    k);
        return f_addr_a(s, k) | (STAGES'(1) << s);
    endfunction

    // Twiddle index pos << (STAGES-1-s). In the last stage 2**s overflows
    // TW_W bits to zero, so the mask wraps to all ones as needed.
    function automatic logic [TW_W-1:0] f_tw(input logic [STAGE_W-1:0] s,
                                             input logic [TW_W-1:0]    k);
        logic [TW_W-1:0] mask;
        mask = (TW_W'(1) << s) - TW_W'(1);
        return (k & mask) << (TW_W - int'(s));
    endfunction

    assign w_ld_en = (r_state == S_LOAD) && bus.i_sample_valid;

    assign bus.o_ld_ready       = (r_state == S_LOAD);
    assign bus.o_ld_en          = w_ld_en;
    assign bus.o_ld_addr        = w_ld_en ? f_bitrev(r_n) : '0;
    assign bus.o_rd_en          = r_rd_en;
    assign bus.o_rd_addr_a      = r_rd_a;
    assign bus.o_rd_addr_b      = r_rd_b;
    assign bus.o_tw_addr        = r_tw;
    assign bus.o_wr_en          = r_wv_p[BFLY_LATENCY-1];
    assign bus.o_wr_addr_a      = r_wa_p[BFLY_LATENCY-1];
    assign bus.o_wr_addr_b      = r_wb_p[BFLY_LATENCY-1];
    assign bus.o_stage          = ((r_state == S_CALC) || (r_state == S_DRAIN)) ? r_s : '0;
    assign bus.o_busy           = r_busy;
    assign bus.o_FFT_cycle_done = r_done;
`ifdef FFT_SCALE_EN
    assign bus.o_wr_scale       = r_wv_p[BFLY_LATENCY-1];
`endif

    // Control FSM. Read outputs are loaded on the transition that enters or
    // continues CALC so the first read appears the cycle after the last load.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_k     <= '0;
            r_s     <= '0;
            r_dcnt  <= '0;
            r_rd_en <= 1'b0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= S_LOAD;
                        r_n     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_ld_en) begin
                        r_n <= r_n + 1'b1;
                        if (r_n == '1) begin
                            r_state <= S_CALC;
                            r_s     <= '0;
                            r_k     <= '0;
                            r_rd_en <= 1'b1;
                            r_rd_a  <= f_addr_a('0, '0);
                            r_rd_b  <= f_addr_b('0, '0);
                            r_tw    <= f_tw('0, '0);
                        end
                    end
                end
                S_CALC: begin
                    if (r_k == '1) begin
                        r_state <= S_DRAIN;
                        r_dcnt  <= '0;
                        r_rd_en <= 1'b0;
                        r_rd_a  <= '0;
                        r_rd_b  <= '0;
                        r_tw    <= '0;
                    end else begin
                        r_k    <= r_k + 1'b1;
                        r_rd_a <= f_addr_a(r_s, r_k + 1'b1);
                        r_rd_b <= f_addr_b(r_s, r_k + 1'b1);
                        r_tw   <= f_tw(r_s, r_k + 1'b1);
                    end
                end
                S_DRAIN: begin
                    if (r_dcnt == LAT_W'(BFLY_LATENCY - 1)) begin
                        if (r_s == STAGE_W'(STAGES - 1)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            r_s     <= r_s + 1'b1;
                            r_k     <= '0;
                            r_rd_en <= 1'b1;
                            r_rd_a  <= f_addr_a(r_s + 1'b1, '0);
                            r_rd_b  <= f_addr_b(r_s + 1'b1, '0);
                            r_tw    <= f_tw(r_s + 1'b1, '0);
                        end
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Write-back delay line: reads replayed as writes BFLY_LATENCY cycles
    // later. Cleared on reset so an abandoned run emits no stray writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wv_p <= '0;
            for (int i = 0; i < BFLY_LATENCY; i++) begin
                r_wa_p[i] <= '0;
                r_wb_p[i] <= '0;
            end
        end else begin
            r_wv_p[0] <= r_rd_en;
            r_wa_p[0] <= r_rd_a;
            r_wb_p[0] <= r_rd_b;
            for (int i = 1; i < BFLY_LATENCY; i++) begin
                r_wv_p[i] <= r_wv_p[i-1];
                r_wa_p[i] <= r_wa_p[i-1];
                r_wb_p[i] <= r_wb_p[i-1];
            end
        end
    end

endmodule

// File: doc/fft_stage_scheduler.md
Name: fft_stage_scheduler

Overview:
Control FSM and address generator for an in-place, iterative radix-2 DIT FFT of N = 2**STAGES points, built on a single shared butterfly unit and a dual-port sample RAM.
- Loads N input samples into the RAM in bit-reversed order.
- Issues one butterfly read per cycle per stage, with matching twiddle address.
- Replays the same addresses as writes after the butterfly pipeline latency.
- Pulses o_FFT_cycle_done when the natural-order result is complete in RAM.

Parameters:
STAGES, 4, number of radix-2 stages; N = 2**STAGES points (16 by default)
BFLY_LATENCY, 2, butterfly pipeline depth in cycles from read-address issue to write-back; legal range 1..8

Ports:
i_clk  in  1  clock; all logic on the rising edge
i_rst  in  1  synchronous active-high reset
i_start  in  1  start one FFT cycle; sampled only in IDLE
i_sample_valid  in  1  input sample present on the datapath this cycle
o_ld_ready  out  1  high in LOAD; a sample is accepted when i_sample_valid && o_ld_ready
o_ld_en  out  1  RAM load write enable (= accepted sample)
o_ld_addr  out  STAGES  bit-reversed load address
o_rd_en  out  1  butterfly operand read enable
o_rd_addr_a  out  STAGES  upper operand address
o_rd_addr_b  out  STAGES  lower operand address
o_tw_addr  out  STAGES-1  twiddle ROM index, W_N^k
o_wr_en  out  1  butterfly result write enable
o_wr_addr_a  out  STAGES  result A address
o_wr_addr_b  out  STAGES  result B address
o_stage  out  max(1,clog2(STAGES))  current stage index
o_busy  out  1  high in every state except IDLE
o_FFT_cycle_done  out  1  one-cycle done pulse

Behaviour:
- Reset: i_rst high at a clock edge forces IDLE and clears all counters and the write-delay pipeline. Every output reads 0 on the following cycle. Reset mid-load or mid-compute abandons the run; no o_wr_en or done pulse follows.
- States: IDLE, LOAD, CALC, DRAIN, DONE.
- IDLE: i_start=1 moves to LOAD and clears sample counter n. i_start in any other state is ignored.
- LOAD: o_ld_ready=1.
  - On each accepted sample: o_ld_en=1 and o_ld_addr=bitrev(n), a combinational output in the same cycle; then n increments.
  - After sample N-1 is accepted, go to CALC with stage s=0 and butterfly k=0.
  - i_sample_valid gaps simply stall.
- CALC: one butterfly per cycle, k = 0..N/2-1.
  - half = 2**s; pos = k mod half; group = k div half.
  - o_rd_addr_a = group*2*half + pos; o_rd_addr_b = o_rd_addr_a + half.
  - o_tw_addr = pos << (STAGES-1-s).
  - o_rd_en=1 and all read addresses and o_tw_addr are registered outputs.
  - After k = N/2-1, go to DRAIN.
- Write path: o_wr_en, o_wr_addr_a and o_wr_addr_b equal o_rd_en, o_rd_addr_a and o_rd_addr_b delayed by exactly BFLY_LATENCY cycles through a shift register.
- DRAIN: lasts BFLY_LATENCY cycles, so the last write of stage s occurs in the final DRAIN cycle.
  - If s < STAGES-1: increment s, reset k, go to CALC. The first read of the new stage is the cycle after the last write, so there is no RAW hazard and no overlap.
  - Otherwise go to DONE.
- o_stage: holds s during CALC/DRAIN and is 0 elsewhere.
- DONE: o_FFT_cycle_done=1 for one cycle, then IDLE.
- Timing: with first CALC read at cycle T, the done pulse occurs at T + STAGES*(N/2 + BFLY_LATENCY). For the defaults this is T+40.
- Output order: results lie in RAM in natural order at addresses 0..N-1.

Optional Feature:
FFT_SCALE_EN
- Defined: adds output o_wr_scale (1 bit), asserted exactly when o_wr_en is asserted. It tells the butterfly to arithmetic-shift results right by 1 per stage (total 1/N scaling, overflow-safe).
- Undefined: the port does not exist and the butterfly writes unscaled.

Test Plan:
1. Reset and idle: hold i_rst 3 cycles, with i_start=1 during reset -> all outputs 0, and IDLE after release until i_start.
2. Load order: i_start, then 16 consecutive valid samples -> o_ld_addr sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, o_ld_ready drops after the 16th, and the next cycle is the first CALC read.
3. Address sequence, defaults:
   - Stage 0, k=0..7 -> (a,b,tw) = (0,1,0),(2,3,0)...(14,15,0).
   - Stage 3, k=7 -> (7,15,7).
   - Stage 2, k=5 -> (9,13,2).
   - Every write mirrors its read 2 cycles later.
4. Timing: first read at T -> stage-1 first read at T+10, last write at T+39, o_FFT_cycle_done high only at T+40, o_busy low at T+41. With BFLY_LATENCY=4 the done pulse is at T+48.
5. Reset mid-operation: assert i_rst during stage 2 CALC -> no further o_wr_en and no done pulse. A new i_start plus 16 samples then completes normally.
6. Gaps and ignored start: insert idle cycles between valid samples and pulse i_start during CALC -> load addresses unchanged, start ignored, and exactly one done pulse.
